// File: rtl/npu_cmp_pkg.sv
// Shared constants, state encoding and width helper for the popcount accumulator.
// A lane code {cout,carry,sum} weighs 4/2/1 and may legally encode only 0..4.
package npu_cmp_pkg;

  localparam int CODE_MAX = 4;
  localparam int CODE_W   = 3;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int partial_w(input int lanes);
    return $clog2(CODE_MAX * lanes + 1);
  endfunction

endpackage

// File: rtl/compressor_accumulator_if.sv
// Compressor-triple input beats plus the frame-result handshake to the activation stage.
// master = producer/consumer environment, slave = the accumulator.
interface compressor_accumulator_if #(
  parameter int LANES = 4,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [LANES-1:0] in_cout;
  logic [LANES-1:0] in_carry;
  logic [LANES-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic             out_err;
  logic             out_sat;

  modport master (
    output in_valid, in_last, in_cout, in_carry, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_err, out_sat
  );

  modport slave (
    input  in_valid, in_last, in_cout, in_carry, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_err, out_sat
  );
endinterface

// File: rtl/cmp_code_decode.sv
// One-lane combinational decode of a compressor triple; codes 5..7 are illegal and count as 0.
// Zero latency, no flow control.
module cmp_code_decode
  import npu_cmp_pkg::*;
(
  input  logic              cout_i,
  input  logic              carry_i,
  input  logic              sum_i,
  output logic [CODE_W-1:0] value_o,
  output logic              illegal_o
);

  assign illegal_o = cout_i & (carry_i | sum_i);
  assign value_o   = illegal_o ? '0 : {cout_i, carry_i, sum_i};

endmodule

// File: rtl/compressor_accumulator.sv
// Per-frame saturating popcount accumulator; result valid the cycle after the edge following the last accept.
// Input is stalled (in_ready=0) from the last beat until the result handshake completes.
module compressor_accumulator
  import npu_cmp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  compressor_accumulator_if.slave bus
);

  localparam int PW = partial_w(LANES);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [CODE_W-1:0] lane_val [LANES];
  logic [LANES-1:0]  lane_err;
  logic [PW-1:0]     partial_d;

  state_e            state_q, state_d;
  logic              s1_valid_q, s1_err_q, s1_last_q;
  logic [PW-1:0]     s1_partial_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              err_q, err_d, sat_q, sat_d;
  logic [ACC_W:0]    acc_sum;
  logic              accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cmp_code_decode u_dec (
      .cout_i   (bus.in_cout[g]),
      .carry_i  (bus.in_carry[g]),
      .sum_i    (bus.in_sum[g]),
      .value_o  (lane_val[g]),
      .illegal_o(lane_err[g])
    );
  end

  always_comb begin
    partial_d = '0;
    for (int l = 0; l < LANES; l++) begin
      partial_d = partial_d + PW'(lane_val[l]);
    end
  end

  assign accept  = bus.in_valid && bus.in_ready;
  // One spare MSB catches the carry out that signals saturation.
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(s1_partial_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    sat_d   = sat_q;
    if (s1_valid_q) begin
      acc_d = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
      sat_d = sat_q | acc_sum[ACC_W];
      err_d = err_q | s1_err_q;
    end
    case (state_q)
      ACCUM: if (accept && bus.in_last) state_d = FLUSH;
      FLUSH: if (s1_valid_q && s1_last_q) state_d = HOLD;
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          err_d   = 1'b0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACCUM;
      s1_valid_q   <= 1'b0;
      s1_partial_q <= '0;
      s1_err_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      acc_q        <= '0;
      err_q        <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_partial_q <= partial_d;
        s1_err_q     <= |lane_err;
        s1_last_q    <= bus.in_last;
      end
      acc_q <= acc_d;
      err_q <= err_d;
      sat_q <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_total = bus.out_valid ? acc_q : '0;
  assign bus.out_err   = bus.out_valid & err_q;
  assign bus.out_sat   = bus.out_valid & sat_q;

endmodule

// File: tb/tb_compressor_accumulator.sv
// Drives a 16-bit and a 6-bit accumulator with identical beats and scores both against a frame-level model.
module tb_compressor_accumulator;
  localparam int LANES = 4;

  typedef logic [3*LANES-1:0] beat_t;
  typedef struct {
    int total16;
    int total6;
    bit err;
    bit sat16;
    bit sat6;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_last, out_ready;
  beat_t            cur;
  logic [LANES-1:0] cout_v, carry_v, sum_v;
  int               checks = 0;
  int               errors = 0;
  exp_t             exp_q[$];
  beat_t            frame_q[$];

  compressor_accumulator_if #(.LANES(LANES), .ACC_W(16)) bus16();
  compressor_accumulator_if #(.LANES(LANES), .ACC_W(6))  bus6();

  compressor_accumulator #(.LANES(LANES), .ACC_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  compressor_accumulator #(.LANES(LANES), .ACC_W(6))  dut6  (.clk(clk), .rst(rst), .bus(bus6));

  always #5 clk = ~clk;

  always_comb begin
    cout_v  = '0;
    carry_v = '0;
    sum_v   = '0;
    for (int l = 0; l < LANES; l++) begin
      cout_v[l]  = cur[3*l+2];
      carry_v[l] = cur[3*l+1];
      sum_v[l]   = cur[3*l];
    end
  end

  assign bus16.in_valid  = in_valid;
  assign bus16.in_last   = in_last;
  assign bus16.in_cout   = cout_v;
  assign bus16.in_carry  = carry_v;
  assign bus16.in_sum    = sum_v;
  assign bus16.out_ready = out_ready;
  assign bus6.in_valid   = in_valid;
  assign bus6.in_last    = in_last;
  assign bus6.in_cout    = cout_v;
  assign bus6.in_carry   = carry_v;
  assign bus6.in_sum     = sum_v;
  assign bus6.out_ready  = out_ready;

  function automatic beat_t mk(input int c0, input int c1, input int c2, input int c3);
    beat_t b;
    b[2:0]   = 3'(c0);
    b[5:3]   = 3'(c1);
    b[8:6]   = 3'(c2);
    b[11:9]  = 3'(c3);
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    int c;
    for (int l = 0; l < LANES; l++) begin
      c = int'($urandom_range(4, 0));
      if ($urandom_range(9, 0) == 0) c = int'($urandom_range(7, 5));
      b[3*l +: 3] = 3'(c);
    end
    return b;
  endfunction

  // Frame total from the code table: legal codes 0..4 add their value, 5..7 flag an error.
  function automatic exp_t model(input beat_t beats[$]);
    exp_t e;
    int p, c;
    e.total16 = 0; e.total6 = 0; e.err = 0; e.sat16 = 0; e.sat6 = 0;
    foreach (beats[b]) begin
      p = 0;
      for (int l = 0; l < LANES; l++) begin
        c = int'(beats[b][3*l +: 3]);
        if (c > 4) e.err = 1; else p += c;
      end
      e.total16 += p;
      if (e.total16 > 65535) begin e.total16 = 65535; e.sat16 = 1; end
      e.total6 += p;
      if (e.total6 > 63) begin e.total6 = 63; e.sat6 = 1; end
    end
    return e;
  endfunction

  task automatic send_beat(input beat_t b, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_last  = last;
    cur      = b;
    @(negedge clk);
    while (bus16.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus16.in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int bubble_max);
    exp_q.push_back(model(frame_q));
    foreach (frame_q[i]) begin
      repeat ($urandom_range(bubble_max, 0)) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        cur      = beat_t'($urandom);
        @(posedge clk); #1;
      end
      send_beat(frame_q[i], i == frame_q.size() - 1);
    end
  endtask

  task automatic scoreboard();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && bus16.out_valid === 1'b1) begin
        checks++;
        if (bus16.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_hold: in_ready=%b required 0", bus16.in_ready);
        end
        if (out_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: total=%0d with no frame pending", bus16.out_total);
          end else begin
            e = exp_q.pop_front();
            if ({bus16.out_total, bus16.out_err, bus16.out_sat} !== {16'(e.total16), e.err, e.sat16}) begin
              errors++;
              $display("FAIL result16: got total=%0d err=%b sat=%b, required total=%0d err=%b sat=%b",
                       bus16.out_total, bus16.out_err, bus16.out_sat, e.total16, e.err, e.sat16);
            end
            checks++;
            if ({bus6.out_valid, bus6.out_total, bus6.out_err, bus6.out_sat} !== {1'b1, 6'(e.total6), e.err, e.sat6}) begin
              errors++;
              $display("FAIL result6: got valid=%b total=%0d err=%b sat=%b, required valid=1 total=%0d err=%b sat=%b",
                       bus6.out_valid, bus6.out_total, bus6.out_err, bus6.out_sat, e.total6, e.err, e.sat6);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus16.in_ready, bus16.out_valid);
    end
    checks++;
    if (bus16.out_total !== 16'd0 || bus16.out_err !== 1'b0 || bus16.out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: total=%0d err=%b sat=%b required 0/0/0", bus16.out_total, bus16.out_err, bus16.out_sat);
    end
    #20 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    frame_q.delete();
    repeat (8) frame_q.push_back(mk(4, 4, 4, 4));
    send_frame(0);
    @(negedge clk);
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: out_valid=%b in_ready=%b required 0/0", bus16.out_valid, bus16.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%b required 1", bus16.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL one_cycle_valid: out_valid=%b in_ready=%b required 0/1", bus16.out_valid, bus16.in_ready);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    logic [15:0] t0;
    logic        e0, s0;
    int          n = 0;
    out_ready = 1'b0;
    frame_q.delete();
    frame_q.push_back(mk(1, 2, 3, 4));
    frame_q.push_back(mk(0, 0, 0, 0));
    frame_q.push_back(mk(2, 2, 2, 2));
    send_frame(1);
    while (bus16.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    t0 = bus16.out_total; e0 = bus16.out_err; s0 = bus16.out_sat;
    checks++;
    if (t0 !== 16'd18) begin
      errors++;
      $display("FAIL stall_total: got %0d required 18", t0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus16.out_valid, bus16.in_ready, bus16.out_total, bus16.out_err, bus16.out_sat} !== {2'b10, t0, e0, s0}) begin
        errors++;
        $display("FAIL stall_stable: valid=%b ready=%b total=%0d required 1/0/%0d",
                 bus16.out_valid, bus16.in_ready, bus16.out_total, t0);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_illegal();
    frame_q.delete();
    frame_q.push_back(mk(5, 1, 1, 1));
    frame_q.push_back(mk(1, 1, 1, 1));
    send_frame(0);
    wait_drain();
    frame_q.delete();
    frame_q.push_back(mk(3, 0, 4, 1));
    frame_q.push_back(mk(2, 2, 0, 1));
    send_frame(0);
    wait_drain();
  endtask

  task automatic test_saturate();
    frame_q.delete();
    repeat (4) frame_q.push_back(mk(4, 4, 4, 4));
    send_frame(0);
    wait_drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) send_beat(mk(4, 3, 2, 1), 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b required 1/0", bus16.in_ready, bus16.out_valid);
    end
    #3 rst = 1'b0;
    @(posedge clk); #1;
    frame_q.delete();
    frame_q.push_back(mk(1, 1, 1, 1));
    send_frame(0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 20; f++) begin
      frame_q.delete();
      frame_q.push_back(rand_beat());
      send_frame(0);
    end
    wait_drain();
    for (int f = 0; f < 20; f++) begin
      frame_q.delete();
      repeat ($urandom_range(5, 1)) frame_q.push_back(rand_beat());
      send_frame(2);
    end
    wait_drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    cur       = '0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_saturate();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
